booth_datapath: RTL and testbench
=================================

Name: booth_datapath

Overview:
- Datapath companion to the Booth-multiplier control unit. It consumes that unit's 2-bit `control` word and returns the 2-bit `status` word (B0, FIN).
- Holds the accumulator, multiplier and multiplicand registers and the shift counter, and produces a signed 2N-bit product.
- The control unit owns sequencing. This block executes one micro-operation per cycle as commanded and reports `done`.

Parameters:
- N, 8, operand width in bits; signed two's complement; N >= 2.
- CW, $clog2(N), shift-counter width.

Ports:
- clk  input  1  system clock, all registers on rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  operand-load request; same signal the control unit receives.
- control  input  2  micro-op: 00 idle/load, 01 add, 10 subtract, 11 shift.
- multiplicand  input  N  signed operand M; sampled only on load.
- multiplier  input  N  signed operand Q; sampled only on load.
- status  output  2  status[1] = B0 (next Booth bit), status[0] = FIN (last shift).
- product  output  2N  signed result {A[N-1:0], Q}.
- busy  output  1  high from load until the final shift completes.
- done  output  1  one-cycle pulse, cycle after the final shift.

Behaviour:
- Registers:
  - A: N+1 bits. The extra bit absorbs the -2^(N-1) multiplicand case.
  - Q: N bits.
  - M: N+1 bits, sign-extended.
  - cnt: CW bits.
  - busy and done: flops.
- Reset (rstn=0, asynchronous): A, Q, M, cnt = 0; busy = 0; done = 0. Hence product = 0 and status = 00 while reset is low.
- control = 00:
  - If start = 1: load A <= 0, Q <= multiplier, M <= sext(multiplicand), cnt <= 0, busy <= 1.
  - If start = 0: hold all registers.
  - If start = 1 while busy = 1: treated as a load (abort and restart). The control unit only drives 00 in its init state.
- control = 01: A <= A + M. Q and cnt hold.
- control = 10: A <= A - M. Q and cnt hold.
- control = 11:
  - {A,Q} <= arithmetic right shift by 1 (A[N] replicated).
  - If cnt == N-1: cnt <= 0 and busy <= 0. Otherwise cnt <= cnt + 1.
- Add/subtract are (N+1)-bit modular, with no overflow flag. The final product is exact in 2N bits for all signed inputs.
- B0 is combinational, selected by control:
  - 00: multiplier[0]. The control unit decides its first step in the same cycle start is high.
  - 01 or 10: Q[0].
  - 11: Q[1], the bit that becomes the LSB after this shift. The control unit decides its next step during the shift cycle.
- FIN is combinational: 1 iff control == 11 and cnt == N-1. It is 0 for all other controls.
- done <= 1 for exactly one cycle after the shift with FIN = 1; otherwise done <= 0.
- product is combinational from registers. It is valid when done = 1 and held unchanged until the next load.
- Latency: 1 load cycle + N shift cycles + k add/sub cycles, where k = number of Booth recoding transitions (0..N). The result is available on the cycle done is high.
- Simultaneous events: none possible within a cycle, since control is one-hot in meaning. Reset overrides everything.
- Reset mid-operation: all state cleared; done is not pulsed. The control unit is reset by the same rstn.
- Undriven/unknown control is not legal. The RTL gives no required response for it beyond holding registers under default case.

Test Plan:
- N=8, load M=3, Q=5 with control unit attached -> done after 1+8+k cycles, product = 0x000F, busy low on the done cycle.
- M=-7 (0xF9), Q=6 -> product = 0xFFD6 (-42); check B0 sequence follows Q[1] on shifts, Q[0] on add/sub.
- M=-128 (0x80), Q=-128 (0x80) -> product = 0x4000 (16384); confirms the N+1-bit accumulator.
- M=0x55, Q=0x55 (alternating bits, maximum add/sub count) -> product = 0x1C39. Also check:
  - FIN asserted only on the 8th shift cycle.
  - Exactly one done pulse.
- Drive control=11 directly with cnt at 7 -> FIN=1; control=01 in the same cnt state -> FIN=0.
- Assert rstn=0 mid-multiply after 3 shifts -> A, Q, M, cnt, busy, done all 0 immediately (asynchronously). A new start then yields the correct product for M=2, Q=-3 -> 0xFFFA.

Source files
------------

// File: rtl/booth_datapath_if.sv
// Booth datapath bus: operand load, micro-op command, status and result.
interface booth_datapath_if #(
    parameter int unsigned N = 8
);
    logic             start;
    logic [1:0]       control;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic [1:0]       status;
    logic [2*N-1:0]   product;
    logic             busy;
    logic             done;

    // Controller side: issues commands and operands, observes results.
    modport master (
        output start, control, multiplicand, multiplier,
        input  status, product, busy, done
    );

    // Datapath side: executes commands, reports status and product.
    modport slave (
        input  start, control, multiplicand, multiplier,
        output status, product, busy, done
    );
endinterface

// File: rtl/booth_datapath.sv
// Booth multiplier datapath: executes one load/add/sub/shift micro-op per cycle.
module booth_datapath #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rstn,
    booth_datapath_if.slave       bus
);
    localparam int unsigned AW = N + 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_SHIFT = 2'b11;

    // Accumulator and multiplicand carry one extra bit so -2^(N-1) negates cleanly.
    logic [AW-1:0] a_q;
    logic [AW-1:0] m_q;
    logic [N-1:0]  q_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic          last_c;
    logic          b0_c;
    logic          fin_c;

    assign last_c = (cnt_q == CW'(N - 1));

    // Micro-op execution and shift counting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q    <= '0;
            m_q    <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (bus.control)
                OP_LOAD: begin
                    if (bus.start) begin
                        a_q    <= '0;
                        q_q    <= bus.multiplier;
                        m_q    <= {bus.multiplicand[N-1], bus.multiplicand};
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                OP_ADD: a_q <= a_q + m_q;
                OP_SUB: a_q <= a_q - m_q;
                OP_SHIFT: begin
                    a_q <= {a_q[AW-1], a_q[AW-1:1]};
                    q_q <= {a_q[0], q_q[N-1:1]};
                    if (last_c) begin
                        cnt_q  <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next Booth bit as seen by the controller in the current command cycle.
    always_comb begin
        b0_c  = 1'b0;
        fin_c = 1'b0;
        case (bus.control)
            OP_LOAD:  b0_c = bus.multiplier[0];
            OP_ADD,
            OP_SUB:   b0_c = q_q[0];
            OP_SHIFT: begin
                b0_c  = q_q[1];
                fin_c = last_c;
            end
            default: ;
        endcase
    end

    // Status is forced quiet while reset is held; result is straight from the registers.
    assign bus.status  = rstn ? {b0_c, fin_c} : 2'b00;
    assign bus.product = {a_q[N-1:0], q_q};
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench: bench-side Booth sequencer drives the datapath, scoreboard checks products.
module tb_booth_datapath;
    localparam int unsigned N = 8;

    logic clk;
    logic rstn;

    booth_datapath_if #(.N(N)) bus ();

    booth_datapath #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding product.
    logic [15:0] mon_exp;
    always @(negedge clk) begin
        if (rstn && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'(0));
            end else begin
                mon_exp = exp_q.pop_front();
                check("product", 32'(bus.product), 32'(mon_exp));
                check("busy_at_done", 32'(bus.busy), 32'(0));
            end
        end
    end

    task automatic apply(input logic st, input logic [1:0] ctl);
        bus.start   = st;
        bus.control = ctl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the monitor to retire every outstanding result.
    task automatic drain();
        for (int k = 0; k < 6 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        check("drain_timeout", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    // Full Booth multiply driven from the operand bits; abort_after>0 resets after that many shifts.
    task automatic run_op(input logic [7:0] m, input logic [7:0] q, input int abort_after);
        logic signed [7:0]  ms;
        logic signed [7:0]  qs;
        logic signed [15:0] p;
        logic prev;
        logic cur;
        ms = m;
        qs = q;
        p  = ms * qs;
        exp_q.push_back(p);

        bus.multiplicand = m;
        bus.multiplier   = q;
        apply(1'b1, 2'b00);
        check("b0_load", 32'(bus.status[1]), 32'(q[0]));
        check("fin_load", 32'(bus.status[0]), 32'(0));
        tick();
        check("busy_after_load", 32'(bus.busy), 32'(1));
        bus.multiplicand = 8'($urandom);
        bus.multiplier   = 8'($urandom);

        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cur = q[i];
            if (cur != prev) begin
                apply(1'b0, cur ? 2'b10 : 2'b01);
                check("b0_addsub", 32'(bus.status[1]), 32'(cur));
                check("fin_addsub", 32'(bus.status[0]), 32'(0));
                tick();
            end
            apply(1'b0, 2'b11);
            check("fin_shift", 32'(bus.status[0]), 32'(i == 7));
            if (i < 7) check("b0_shift", 32'(bus.status[1]), 32'(q[i+1]));
            tick();
            prev = cur;
            if (abort_after > 0 && i + 1 == abort_after) begin
                apply(1'b0, 2'b00);
                rstn = 1'b0;
                #1;
                check("abort_product", 32'(bus.product), 32'(0));
                check("abort_status", 32'(bus.status), 32'(0));
                check("abort_busy", 32'(bus.busy), 32'(0));
                check("abort_done", 32'(bus.done), 32'(0));
                exp_q.delete();
                tick();
                rstn = 1'b1;
                tick();
                return;
            end
        end
        apply(1'b0, 2'b00);
        drain();
    endtask

    initial begin
        rstn             = 1'b0;
        bus.start        = 1'b0;
        bus.control      = 2'b00;
        bus.multiplicand = 8'h00;
        bus.multiplier   = 8'h01;
        #2;
        check("rst_product", 32'(bus.product), 32'(0));
        check("rst_status", 32'(bus.status), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        tick();
        tick();
        rstn = 1'b1;
        tick();

        run_op(8'h03, 8'h05, 0);
        run_op(8'hF9, 8'h06, 0);
        run_op(8'h80, 8'h80, 0);
        run_op(8'h55, 8'h55, 0);
        run_op(8'h7F, 8'h80, 0);
        run_op(8'h80, 8'h7F, 0);

        // Shift-only pass to reach the last count, then probe FIN under add vs shift.
        exp_q.push_back(16'h0000);
        bus.multiplicand = 8'h11;
        bus.multiplier   = 8'hA5;
        apply(1'b1, 2'b00);
        tick();
        for (int i = 0; i < 7; i++) begin
            apply(1'b0, 2'b11);
            check("fin_early", 32'(bus.status[0]), 32'(0));
            tick();
        end
        apply(1'b0, 2'b01);
        check("fin_add_at_last", 32'(bus.status[0]), 32'(0));
        apply(1'b0, 2'b11);
        check("fin_shift_at_last", 32'(bus.status[0]), 32'(1));
        tick();
        apply(1'b0, 2'b00);
        drain();

        run_op(8'h55, 8'hC3, 3);
        run_op(8'h02, 8'hFD, 0);

        for (int t = 0; t < 40; t++) begin
            run_op(8'($urandom), 8'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
